// File: rtl/click_game_pkg.sv
// click_game_pkg: shared types, mode constants and width helper for the click game arena.
package click_game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic MODE_RACE  = 1'b0;
    localparam logic MODE_TIMED = 1'b1;

    // Width of a player index; a single player still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/click_edge_det.sv
// click_edge_det: synchronises one raw button and emits a one-cycle pulse per rising edge.
//   clk   - system clock
//   reset - asynchronous active-low reset
//   din   - raw asynchronous button level
//   pulse - high for one cycle after each synchronised 0->1 transition
module click_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign pulse = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/click_game_arena.sv
// click_game_arena: multi-player click counting game with timed and race modes.
//   clk       - system clock, rising edge
//   reset     - asynchronous active-low reset
//   en        - global enable; low freezes timer and scoring
//   start     - level request to begin a game
//   up        - mode select sampled at game start (1 timed, 0 race)
//   click     - raw player buttons
//   score     - packed per-player scores, player i at [i*CNT_W +: CNT_W]
//   time_left - remaining window cycles
//   busy      - game running
//   done      - game finished, result valid
//   winner    - lowest-index leader
//   tie       - more than one leader
//   sat       - per-player score pinned at the upper rail
module click_game_arena
    import click_game_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int CNT_W       = 7,
    parameter int GAME_CYCLES = 1000,
    parameter int TARGET      = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 en,
    input  logic                                 start,
    input  logic                                 up,
    input  logic [NUM_PLAYERS-1:0]               click,
    output logic [NUM_PLAYERS*CNT_W-1:0]         score,
    output logic [$clog2(GAME_CYCLES+1)-1:0]     time_left,
    output logic                                 busy,
    output logic                                 done,
    output logic [idx_w(NUM_PLAYERS)-1:0]        winner,
    output logic                                 tie,
    output logic [NUM_PLAYERS-1:0]               sat
);

    localparam int TW = $clog2(GAME_CYCLES + 1);
    localparam int WW = idx_w(NUM_PLAYERS);
    localparam logic [CNT_W-1:0] MAX_SCORE = '1;

    state_t                 state, state_n;
    logic                   mode;
    logic [CNT_W-1:0]       sc   [NUM_PLAYERS];
    logic [CNT_W-1:0]       sc_n [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] pulse;
    logic [NUM_PLAYERS-1:0] sat_n;
    logic [CNT_W-1:0]       best;
    logic [WW-1:0]          best_idx;
    logic                   tie_n;
    logic                   any_zero;
    logic                   go;
    logic                   step;
    logic                   finish;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
        click_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_det (
            .clk  (clk),
            .reset(reset),
            .din  (click[g]),
            .pulse(pulse[g])
        );
        assign score[g*CNT_W +: CNT_W] = sc[g];
    end

    assign go   = (state == IDLE) && start && en;
    assign step = (state == RUN) && en;
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Scores one cycle ahead; edges outside an enabled RUN are dropped here.
    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            sc_n[i] = sc[i];
            if (step && pulse[i]) begin
                if (mode == MODE_TIMED)
                    sc_n[i] = (sc[i] == MAX_SCORE) ? sc[i] : sc[i] + 1'b1;
                else
                    sc_n[i] = (sc[i] == '0) ? sc[i] : sc[i] - 1'b1;
            end
            sat_n[i] = (mode == MODE_TIMED) && (sc_n[i] == MAX_SCORE);
        end
    end

    // Leader scan on the next scores so the edge landing on the final cycle counts.
    always_comb begin
        best     = sc_n[0];
        best_idx = '0;
        tie_n    = 1'b0;
        any_zero = 1'b0;
        for (int i = 1; i < NUM_PLAYERS; i++) begin
            if ((mode == MODE_TIMED) ? (sc_n[i] > best) : (sc_n[i] < best)) begin
                best     = sc_n[i];
                best_idx = WW'(i);
            end
        end
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (sc_n[i] == best && WW'(i) != best_idx)
                tie_n = 1'b1;
            if (sc_n[i] == '0)
                any_zero = 1'b1;
        end
    end

    assign finish = step && ((time_left == TW'(1)) || (mode == MODE_RACE && any_zero));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = go ? RUN : IDLE;
            RUN:     state_n = finish ? DONE : RUN;
            DONE:    state_n = start ? DONE : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode      <= MODE_RACE;
            time_left <= '0;
            winner    <= '0;
            tie       <= 1'b0;
            sat       <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++)
                sc[i] <= '0;
        end else if (go) begin
            mode      <= up;
            time_left <= TW'(GAME_CYCLES);
            winner    <= '0;
            tie       <= 1'b0;
            sat       <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++)
                sc[i] <= up ? '0 : CNT_W'(TARGET);
        end else if (step) begin
            time_left <= time_left - 1'b1;
            sat       <= sat_n;
            sc        <= sc_n;
            if (finish) begin
                winner <= best_idx;
                tie    <= tie_n;
            end
        end
    end

endmodule

// File: tb/tb_click_game_arena.sv
// tb_click_game_arena: randomized scoreboard bench for click_game_arena (4 players, 3-bit scores).
module tb_click_game_arena;
    import click_game_pkg::*;

    localparam int NP   = 4;
    localparam int CW   = 3;
    localparam int GC   = 100;
    localparam int TG   = 4;
    localparam int SS   = 2;
    localparam int TW   = $clog2(GC + 1);
    localparam int WW   = 2;
    localparam int MAXS = (1 << CW) - 1;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             en    = 1'b0;
    logic             start = 1'b0;
    logic             up    = 1'b0;
    logic [NP-1:0]    click = '0;
    logic [NP*CW-1:0] score;
    logic [TW-1:0]    time_left;
    logic             busy;
    logic             done;
    logic [WW-1:0]    winner;
    logic             tie;
    logic [NP-1:0]    sat;

    always #5 clk = ~clk;

    click_game_arena #(
        .NUM_PLAYERS(NP),
        .CNT_W      (CW),
        .GAME_CYCLES(GC),
        .TARGET     (TG),
        .SYNC_STAGES(SS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .start    (start),
        .up       (up),
        .click    (click),
        .score    (score),
        .time_left(time_left),
        .busy     (busy),
        .done     (done),
        .winner   (winner),
        .tie      (tie),
        .sat      (sat)
    );

    typedef struct packed {
        logic             early;
        logic [NP*CW-1:0] sc;
        logic [NP-1:0]    sat;
        logic [WW-1:0]    win;
        logic             tie;
        logic [15:0]      lat;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: clicks land in aligned slots, so a race ends once TARGET slots pass;
    // a timed score is the click count clipped to the rail.
    function automatic exp_t model(input logic timed, input int c[NP], input int pause);
        exp_t e;
        int   s[NP];
        int   w = 0;
        int   n = 0;
        e     = '0;
        e.lat = 16'(GC + pause);
        for (int p = 0; p < NP; p++) begin
            s[p] = timed ? (c[p] > MAXS ? MAXS : c[p]) : TG - (c[p] > TG ? TG : c[p]);
            e.sc[p*CW +: CW] = CW'(s[p]);
            e.sat[p] = timed && (c[p] >= MAXS);
            if (!timed && c[p] >= TG)
                e.early = 1'b1;
        end
        for (int p = 1; p < NP; p++)
            if (timed ? (s[p] > s[w]) : (s[p] < s[w]))
                w = p;
        for (int p = 0; p < NP; p++)
            if (s[p] == s[w])
                n++;
        e.win = WW'(w);
        e.tie = (n > 1);
        return e;
    endfunction

    // Monitor: compares the result each time done rises.
    initial begin
        int   run   = 0;
        logic dprev = 1'b0;
        logic bprev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy)
                run = bprev ? run + 1 : 1;
            if (done && !dprev) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = q.pop_front();
                    for (int p = 0; p < NP; p++)
                        chk($sformatf("score%0d", p), 32'(score[p*CW +: CW]), 32'(e.sc[p*CW +: CW]));
                    chk("sat", 32'(sat), 32'(e.sat));
                    chk("winner", 32'(winner), 32'(e.win));
                    chk("tie", 32'(tie), 32'(e.tie));
                    if (e.early) begin
                        chk("time_left_nonzero", 32'(time_left != '0), 32'(1));
                    end else begin
                        chk("latency", 32'(run), 32'(e.lat));
                        chk("time_left_end", 32'(time_left), 32'(0));
                    end
                end
            end
            dprev = done;
            bprev = busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic play(input logic timed, input int c0, input int c1, input int c2,
                        input int c3, input int pause_slot, input int hold);
        int c[NP];
        int maxc = 0;
        int w    = 0;
        c = '{c0, c1, c2, c3};
        for (int p = 0; p < NP; p++)
            if (c[p] > maxc)
                maxc = c[p];
        en    = 1'b1;
        up    = timed;
        start = 1'b1;
        q.push_back(model(timed, c, (pause_slot >= 0 && pause_slot <= maxc) ? 10 : 0));
        tick(1);
        up = ~timed;
        for (int s = 0; s <= maxc; s++) begin
            if (s == pause_slot) begin
                // Frozen window: a press made entirely inside it must not score.
                en = 1'b0;
                tick(1);
                click = '1;
                tick(2);
                click = '0;
                tick(7);
                en = 1'b1;
            end
            if (s < maxc) begin
                for (int p = 0; p < NP; p++)
                    click[p] = (c[p] > s);
                tick($urandom_range(2, 5));
                click = '0;
                tick(2);
            end
        end
        while (!done && w < GC + 40) begin
            tick(1);
            w++;
        end
        if (!done) begin
            errors++;
            vectors++;
            $display("FAIL done_timeout: got done=0, expected done=1 within %0d cycles", GC + 40);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
            $finish;
        end
        tick(hold);
        chk("start_held_done", 32'(done), 32'(1));
        chk("start_held_busy", 32'(busy), 32'(0));
        start = 1'b0;
        tick(1);
        chk("idle_done", 32'(done), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_score"}, 32'(score), 32'(0));
        chk({tag, "_time_left"}, 32'(time_left), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_winner"}, 32'(winner), 32'(0));
        chk({tag, "_tie"}, 32'(tie), 32'(0));
        chk({tag, "_sat"}, 32'(sat), 32'(0));
    endtask

    initial begin
        #2;
        chk_zero("reset");
        tick(3);
        reset = 1'b1;
        tick(2);
        play(1'b1, 5, 3, 0, 0, -1, 3);
        play(1'b0, 4, 4, 1, 0, -1, 3);
        play(1'b1, 2, 6, 6, 1, 3, 4);
        play(1'b1, 0, 10, 2, 0, -1, 2);
        play(1'b0, 1, 2, 3, 2, 1, 3);
        for (int g = 0; g < 10; g++)
            play(1'(($urandom_range(0, 1))), $urandom_range(0, 10), $urandom_range(0, 10),
                 $urandom_range(0, 10), $urandom_range(0, 10),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(0, 6) : -1, $urandom_range(2, 6));
        // Asynchronous reset in the middle of a running game.
        en    = 1'b1;
        up    = 1'b1;
        start = 1'b1;
        tick(1);
        for (int s = 0; s < 3; s++) begin
            click = (s < 2) ? 4'b0011 : 4'b0001;
            tick(2);
            click = '0;
            tick(2);
        end
        chk("pre_reset_busy", 32'(busy), 32'(1));
        chk("pre_reset_score", 32'(score), 32'({3'd0, 3'd0, 3'd2, 3'd3}));
        #2;
        reset = 1'b0;
        #1;
        chk_zero("async_reset");
        tick(1);
        start = 1'b0;
        reset = 1'b1;
        tick(2);
        chk("post_reset_busy", 32'(busy), 32'(0));
        chk("post_reset_done", 32'(done), 32'(0));
        play(1'b1, 3, 1, 1, 0, -1, 2);
        tick(5);
        chk("scoreboard_empty", 32'(q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/click_game_arena.md
Name: click_game_arena

Overview:
- Parametrised successor to the two-player click-counting game.
- Counts debounced click edges from NUM_PLAYERS buttons inside a timed window (timed mode) or as a countdown race to zero (race mode).
- Declares a winner or a tie, and exposes per-player binary scores for downstream seven-segment decode.
- Sits between the board button inputs and the display and LED logic.

Parameters:
- NUM_PLAYERS, 2: number of click channels (2..8).
- CNT_W, 7: score width per player.
- GAME_CYCLES, 1000: length of the timed window in enabled clock cycles.
- TARGET, 20: race-mode start value; must be at most 2^CNT_W-1.
- SYNC_STAGES, 2: click synchroniser depth (at least 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  global enable; low freezes timer and scoring.
- start  in  1  level request to begin a game.
- up  in  1  mode select, sampled on game start: 1 = timed, 0 = race.
- click  in  NUM_PLAYERS  raw asynchronous player buttons.
- score  out  NUM_PLAYERS*CNT_W  packed scores; player i occupies [i*CNT_W +: CNT_W].
- time_left  out  $clog2(GAME_CYCLES+1)  remaining window cycles.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- winner  out  $clog2(NUM_PLAYERS) (min 1)  winning player index, valid when done=1.
- tie  out  1  more than one leader at game end, valid when done=1.
- sat  out  NUM_PLAYERS  per-player score saturated at the rail.

Behaviour:
- Reset (reset=0, asynchronous) forces the following; the game state is cleared immediately, including mid-game:
  - FSM to IDLE.
  - scores, time_left, busy, done, winner, tie, sat all 0.
  - synchroniser flops and edge-detector history to 0.
- Click path:
  - Each click bit passes through a SYNC_STAGES flop chain, then a rising-edge detector (sync & ~prev).
  - A raw input 0→1 change updates score on the (SYNC_STAGES+1)th rising clk edge after it is sampled.
  - Held buttons count once.
  - Edge detectors run even when en=0, but edges occurring while en=0 or outside RUN are discarded.
- FSM states: IDLE, RUN, DONE (enum in package).
  - IDLE→RUN: start=1 && en=1. On entry:
    - latch mode from up;
    - time_left <= GAME_CYCLES;
    - scores <= 0 in timed mode, TARGET in race mode;
    - sat, tie, winner cleared.
  - RUN:
    - While en=1, time_left decrements by 1 per cycle.
    - Each detected edge increments (timed) or decrements (race) that player's score.
    - While en=0, all RUN state holds.
  - RUN→DONE, timed mode: on the cycle time_left goes 1→0.
    - Edges arriving in that same cycle are still counted.
    - Result uses the final scores.
  - RUN→DONE, race mode: on the cycle any score reaches 0, or on timeout.
    - Winner is among players at 0.
    - Timeout with nobody at 0: lowest score leads.
  - DONE→IDLE: start=0. A start held high therefore never auto-restarts a game.
  - start and up changes during RUN are ignored.
- Arithmetic:
  - Timed mode saturates at 2^CNT_W-1 with sat[i]=1; further clicks are ignored.
  - Race mode saturates at 0; a player at 0 stays 0.
  - No wrap-around in either mode.
- Result:
  - winner = lowest index among leaders.
  - tie = 1 iff two or more players share the leading value, including simultaneous arrival at 0 in race mode.
  - winner and tie are registered on entry to DONE and held until the next game start or reset.
  - Scores hold their values in DONE and IDLE until the next game start.

Decomposition:
- Package click_game_pkg:
  - state enum (IDLE, RUN, DONE);
  - mode constants (MODE_RACE=0, MODE_TIMED=1);
  - a width helper function for the winner index.
- Sub-module click_edge_det:
  - parameter SYNC_STAGES;
  - ports clk, reset, din, pulse;
  - instantiated once per player via generate.
- Leader selection is combinational inside the top: a linear scan over NUM_PLAYERS.

Test Plan:
- Timed basic, NUM_PLAYERS=2, GAME_CYCLES=20, up=1: player0 clicks 5 times, player1 clicks 3 times, start=1 → done after 20 cycles, score0=5, score1=3, winner=0, tie=0.
- Race with simultaneous finish, TARGET=4, up=0: both players click 4 times with aligned edges → both scores 0 in the same cycle, done=1, tie=1, winner=0, with time_left>0 at exit.
- Saturation, CNT_W=3, GAME_CYCLES=40, up=1: player1 gives 10 clicks → score1=7 and sat[1]=1 from the 7th click; held button counts once.
- Enable pause: drop en for 10 cycles mid-RUN while clicking → time_left and scores frozen; done arrives 10 cycles later than in the unpaused run.
- Reset mid-game: assert reset=0 during RUN with scores 3 and 2 → all outputs 0 and busy=0 asynchronously; after release the FSM is in IDLE.
- Start held: keep start=1 through DONE → no new game until start returns low and then rises again; 4-player build (NUM_PLAYERS=4) with clicks 2/6/6/1 → winner=1, tie=1.
